mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one external memory bus between the instruction-fetch port (IF stage) and the data-memory port (DM stage) of the 5-stage pipeline.
- Accepts level requests from both stages and arbitrates them round-robin.
- Issues one bus transaction at a time with a req/gnt request phase and an rvalid response phase.
- Returns read data and a one-cycle done pulse.
- Drives stall_f / stall_m, which the hazard logic ORs into its pipeline stall controls.

Parameters:
ADDR_W, 32, address width of both ports and the bus
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
if_req  in  1  fetch request, level, held until if_done or if_kill
if_addr  in  ADDR_W  fetch address
if_kill  in  1  branch flush: abandon the current/pending fetch
if_rdata  out  DATA_W  fetched instruction, registered
if_done  out  1  one-cycle pulse: if_rdata valid
dm_req  in  1  data request, level, held until dm_done
dm_we  in  1  1 = store, 0 = load
dm_be  in  DATA_W/8  store byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, registered
dm_done  out  1  one-cycle pulse: access complete
bus_req  out  1  request phase valid
bus_we  out  1  write strobe
bus_be  out  DATA_W/8  byte enables
bus_addr  out  ADDR_W  address
bus_wdata  out  DATA_W  write data
bus_gnt  in  1  bus accepts request this cycle
bus_rvalid  in  1  response (read data or write ack)
bus_rdata  in  DATA_W  read data
stall_f  out  1  fetch stall
stall_m  out  1  memory-stage stall

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. Register `owner` (IF/DM) records the current transaction's requester. Register `last` (IF/DM) records the last granted requester.
- Reset (async, immediate): state=IDLE, last=IF. All registered outputs are 0: bus_*, if_rdata, dm_rdata, if_done, dm_done. A transaction in flight is dropped; no done pulse is issued.
- IDLE:
  - dm_req and if_req (with if_kill=0) both high: grant the requester that is not `last`. After reset, DM wins the first tie.
  - Only one request valid: grant it.
  - On grant: load bus_addr/we/be/wdata registers; set owner, last; go to ISSUE.
  - IF grant drives we=0, be=all ones, wdata=0.
- ISSUE:
  - bus_req=1. Address, we, be and wdata stay stable until bus_gnt.
  - bus_gnt=1: go to WAIT; bus_req deasserts the next cycle.
  - owner=IF and if_kill=1 before gnt: go to IDLE, bus_req=0 next cycle, no if_done.
  - A kill and gnt in the same cycle counts as a gnt; the kill then applies in WAIT.
- WAIT:
  - bus_req=0. Wait for bus_rvalid.
  - On rvalid: capture bus_rdata into if_rdata or dm_rdata (loads and fetches only; stores leave dm_rdata unchanged). Go to DONE.
  - A kill seen in WAIT sets a killed flag. The bus transaction still completes. At rvalid with killed set: no capture, no if_done; go directly to IDLE.
- DONE:
  - Exactly one cycle. The owner's done pulses.
  - No arbitration this cycle, because the requester's req is still high for the completed access. Next state is IDLE.
- Minimum latency (gnt in the ISSUE cycle, rvalid in the first WAIT cycle): request sampled in IDLE at cycle 0, done at cycle 3.
- bus_rvalid or bus_gnt outside ISSUE/WAIT: ignored.
- if_kill while the FSM serves DM or is idle: no effect, except that it masks if_req in IDLE arbitration that cycle.
- Stalls are combinational:
  - stall_f = if_req & ~if_kill & ~if_done.
  - stall_m = dm_req & ~dm_done.
  - Both are forced to 0 while reset is high.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x100; gnt in ISSUE; rvalid rdata=0x00000013 one cycle later -> bus_req high in cycle 1 only; if_done=1 in cycle 3 with if_rdata=0x13; stall_f high cycles 0-2, low cycle 3.
2. Tie after reset: store dm_addr=0x2000, wdata=0xDEADBEEF, be=0xF, together with fetch 0x104 -> DM serviced first (bus_we=1), then IF. Tie re-raised next -> IF first. dm_rdata unchanged by the store.
3. Backpressure: bus_gnt low for 4 cycles in ISSUE -> bus_req, bus_addr, bus_be, bus_wdata, bus_we constant over all 5 cycles; WAIT entered only after gnt.
4. Kill: if_kill in ISSUE -> IDLE next cycle, bus_req=0, no if_done. Kill in WAIT, then rvalid with rdata=0xAAAA5555 -> if_rdata keeps its old value, no if_done.
5. Reset mid-WAIT: assert reset -> bus_req=0, all dones 0, state IDLE immediately. A stale rvalid after reset release is ignored; the next request completes normally.
6. Spurious bus_rvalid=1 in IDLE with rdata=0x12345678 -> no done pulse, no rdata register change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory bus between the IF fetch port and the DM data port.
// One transaction in flight at a time: req/gnt request phase, then an rvalid response phase.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_f,
  output logic                stall_m
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state, state_nx;
  logic   owner;   // 1 = DM owns the current transaction
  logic   last;    // 1 = DM was granted last
  logic   killed;
  logic   if_vld, pick_dm, grant, kill_own;

  assign if_vld   = if_req & ~if_kill;
  assign grant    = dm_req | if_vld;
  // On a tie the side that was not granted last wins
  assign pick_dm  = dm_req & (~if_vld | ~last);
  assign kill_own = ~owner & if_kill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (bus_gnt)       state_nx = S_WAIT;
        else if (kill_own) state_nx = S_IDLE;
      end
      S_WAIT:  if (bus_rvalid) state_nx = (killed | kill_own) ? S_IDLE : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req = (state == S_ISSUE);
    if_done = (state == S_DONE) & ~owner;
    dm_done = (state == S_DONE) & owner;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      last      <= 1'b0;
      killed    <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: if (grant) begin
          owner     <= pick_dm;
          last      <= pick_dm;
          killed    <= 1'b0;
          bus_addr  <= pick_dm ? dm_addr : if_addr;
          bus_we    <= pick_dm & dm_we;
          bus_be    <= pick_dm ? dm_be : '1;
          bus_wdata <= pick_dm ? dm_wdata : '0;
        end
        // A kill coinciding with gnt lets the access go out but discards its response
        S_ISSUE: if (bus_gnt) killed <= kill_own;
        S_WAIT: begin
          if (kill_own) killed <= 1'b1;
          if (bus_rvalid && !(killed || kill_own)) begin
            if (!owner)       if_rdata <= bus_rdata;
            else if (!bus_we) dm_rdata <= bus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_f = ~reset & if_req & ~if_kill & ~if_done;
  assign stall_m = ~reset & dm_req & ~dm_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed smoke tests, then randomized requesters and bus slave against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4;

  logic          clk = 1'b0, reset = 1'b0;
  logic          if_req = 1'b0, if_kill = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [BW-1:0] dm_be = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, dm_rdata;
  logic          dm_done;
  logic          bus_req, bus_we;
  logic [BW-1:0] bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          stall_f, stall_m;
  int            n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, its phase, and the expected read registers
  typedef struct packed {
    logic          dm;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          cur;
  bit            busy, accepted, killed, done_now, last_dm;
  logic [DW-1:0] exp_if_rdata, exp_dm_rdata;

  task automatic model_reset();
    busy = 0; accepted = 0; killed = 0; done_now = 0; last_dm = 0;
    cur = '0; exp_if_rdata = '0; exp_dm_rdata = '0;
  endtask

  task automatic model_step();
    bit ifv, own_kill, pick;
    ifv      = if_req && !if_kill;
    own_kill = busy && !cur.dm && if_kill;
    if (done_now) done_now = 0;
    else if (!busy) begin
      if (dm_req || ifv) begin
        pick    = dm_req && (!ifv || !last_dm);
        last_dm = pick;
        if (pick) cur = '{1'b1, dm_addr, dm_we, dm_be, dm_wdata};
        else      cur = '{1'b0, if_addr, 1'b0, {BW{1'b1}}, {DW{1'b0}}};
        busy = 1; accepted = 0; killed = 0;
      end
    end else if (!accepted) begin
      if (bus_gnt) begin accepted = 1; killed = own_kill; end
      else if (own_kill) busy = 0;
    end else begin
      killed = killed || own_kill;
      if (bus_rvalid) begin
        busy = 0;
        if (!killed) begin
          done_now = 1;
          if (!cur.dm)     exp_if_rdata = bus_rdata;
          else if (!cur.we) exp_dm_rdata = bus_rdata;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit e_breq, e_ifd, e_dmd;
    e_breq = busy && !accepted;
    e_ifd  = done_now && !cur.dm;
    e_dmd  = done_now && cur.dm;
    chk("bus_req", 64'(bus_req), 64'(e_breq));
    chk("if_done", 64'(if_done), 64'(e_ifd));
    chk("dm_done", 64'(dm_done), 64'(e_dmd));
    chk("stall_f", 64'(stall_f), 64'(if_req && !if_kill && !e_ifd));
    chk("stall_m", 64'(stall_m), 64'(dm_req && !e_dmd));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    chk("dm_rdata", 64'(dm_rdata), 64'(exp_dm_rdata));
    if (e_breq) begin
      chk("bus_addr", 64'(bus_addr), 64'(cur.addr));
      chk("bus_we", 64'(bus_we), 64'(cur.we));
      chk("bus_be", 64'(bus_be), 64'(cur.be));
      chk("bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_bus_req"}, 64'(bus_req), 64'(0));
    chk({tag, "_if_done"}, 64'(if_done), 64'(0));
    chk({tag, "_dm_done"}, 64'(dm_done), 64'(0));
    chk({tag, "_stall_f"}, 64'(stall_f), 64'(0));
    chk({tag, "_stall_m"}, 64'(stall_m), 64'(0));
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
    chk({tag, "_dm_rdata"}, 64'(dm_rdata), 64'(0));
    chk({tag, "_bus_addr"}, 64'(bus_addr), 64'(0));
    chk({tag, "_bus_we"}, 64'(bus_we), 64'(0));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    if_req = 0; if_kill = 0; dm_req = 0; bus_gnt = 0; bus_rvalid = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bit was_ifd, was_dmd;
    #2 reset = 1'b1;
    #1 check_reset_state("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single fetch at minimum latency
    if_req = 1; if_addr = 32'h100; bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h13;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_bus_req", 64'(bus_req), 64'(c == 1));
      chk("t1_if_done", 64'(if_done), 64'(c == 3));
      chk("t1_stall_f", 64'(stall_f), 64'(c < 3));
      if (c == 1) chk("t1_addr", 64'(bus_addr), 64'h100);
      if (c == 3) chk("t1_if_rdata", 64'(if_rdata), 64'h13);
      @(posedge clk); #1;
    end
    if_req = 0;
    pulse_reset();

    // Tie after reset: DM store first, then pending IF beats the re-raised DM load
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h104; bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'h0BADF00D;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t2_bus_req", 64'(bus_req), 64'(c == 1 || c == 5 || c == 9));
      chk("t2_dm_done", 64'(dm_done), 64'(c == 3 || c == 11));
      chk("t2_if_done", 64'(if_done), 64'(c == 7));
      if (c == 1) begin
        chk("t2_dm_addr", 64'(bus_addr), 64'h2000);
        chk("t2_dm_we", 64'(bus_we), 64'(1));
        chk("t2_dm_wdata", 64'(bus_wdata), 64'hDEADBEEF);
      end
      if (c == 5) begin
        chk("t2_if_addr", 64'(bus_addr), 64'h104);
        chk("t2_if_we", 64'(bus_we), 64'(0));
        chk("t2_if_be", 64'(bus_be), 64'hF);
        chk("t2_if_wdata", 64'(bus_wdata), 64'(0));
      end
      if (c == 7) chk("t2_store_keeps_rdata", 64'(dm_rdata), 64'(0));
      if (c == 9) chk("t2_ld_addr", 64'(bus_addr), 64'h3000);
      if (c == 11) chk("t2_dm_rdata", 64'(dm_rdata), 64'h0BADF00D);
      @(posedge clk); #1;
      if (c == 3) begin dm_we = 0; dm_addr = 32'h3000; end
      if (c == 7) if_req = 0;
      if (c == 11) dm_req = 0;
    end
    pulse_reset();

    // Randomized traffic with occasional asynchronous resets mid-flight
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      was_ifd = done_now && !cur.dm;
      was_dmd = done_now && cur.dm;
      model_step();
      if_kill = 0;
      if (was_ifd) if_req = 0;
      if (was_dmd) dm_req = 0;
      if (if_req && $urandom_range(0, 9) == 0) begin
        if_kill = 1;
        if_addr = $urandom & ~32'h3;
      end else if (!if_req && $urandom_range(0, 19) == 0) begin
        if_kill = 1;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1;
        if_addr = $urandom & ~32'h3;
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req   = 1;
        dm_we    = 1'($urandom);
        dm_be    = 4'($urandom);
        dm_addr  = $urandom & ~32'h3;
        dm_wdata = $urandom;
      end
      bus_gnt    = 1'($urandom_range(0, 1));
      bus_rvalid = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      @(negedge clk);
      check_outputs();
      if (cyc % 700 == 350) begin
        #2 reset = 1'b1;
        #1 check_reset_state("midrst");
        model_reset();
        if_req = 0; if_kill = 0; dm_req = 0;
        @(posedge clk); #1;
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
